tmds_rx_decoder: RTL and testbench

- Receive-side counterpart of the HDMI TMDS transmitter path.
- Accepts the three parallel 10-bit TMDS channel words, already deserialized and word-aligned, on the pixel clock.
- Decodes them back to 8-bit RGB plus DE/HSYNC/VSYNC, and recovers pixel/line counters, line/frame strobes, a lock indication and a symbol error flag.
- Used in loopback benches and on-board self-check of the pattern/PanoCore output.

---
 rtl/tmds_rx_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_tmds_rx_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: turns three aligned 10-bit channel words back into RGB/DE/sync,
// and recovers pixel/line counters, line/frame strobes, a lock flag and a symbol error pulse.
//
// lock state | meaning
// -----------+---------------------------------------------------------------
// S_UNLOCKED | counting consecutive good lines in gl_q, o_locked=0
// S_LOCKED   | LOCK_LINES good lines seen with no error since, o_locked=1
module tmds_rx_decoder #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int LOCK_LINES   = 4,
  parameter bit VSYNC_ACTIVE = 1'b1
) (
  input  logic        i_pixclk,
  input  logic        i_reset_n,
  input  logic [9:0]  i_TMDS_red,
  input  logic [9:0]  i_TMDS_grn,
  input  logic [9:0]  i_TMDS_blu,
  output logic [7:0]  o_red,
  output logic [7:0]  o_grn,
  output logic [7:0]  o_blu,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount,
  output logic        o_newline,
  output logic        o_newframe,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [9:0]  TOK_C00 = 10'b1101010100;
  localparam logic [9:0]  TOK_C01 = 10'b0010101011;
  localparam logic [9:0]  TOK_C10 = 10'b0101010100;
  localparam logic [9:0]  TOK_C11 = 10'b1010101011;
  localparam logic [11:0] HC_MAX  = 12'hfff;
  localparam logic [11:0] H_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST  = 12'(V_ACTIVE - 1);
  localparam int          GL_W    = $clog2(LOCK_LINES + 1);
  localparam logic [GL_W-1:0] GL_MAX = GL_W'(LOCK_LINES);

  typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} lock_state_t;

  function automatic logic is_ctl(input logic [9:0] w);
    return (w == TOK_C00) || (w == TOK_C01) || (w == TOK_C10) || (w == TOK_C11);
  endfunction

  function automatic logic [1:0] ctl_code(input logic [9:0] w);
    case (w)
      TOK_C01: return 2'b01;
      TOK_C10: return 2'b10;
      TOK_C11: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] m;
    logic [7:0] d;
    m    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = m[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
    end
    return d;
  endfunction

  // stage 1
  logic [9:0] red_s1_q, grn_s1_q, blu_s1_q;
  logic [9:0] red_s1_d, grn_s1_d, blu_s1_d;
  logic       vld_s1_q, vld_s1_d;

  // stage 2
  logic [7:0]  red_q, grn_q, blu_q, red_d, grn_d, blu_d;
  logic        de_q, hsync_q, vsync_q, de_d, hsync_d, vsync_d;
  logic [11:0] hcount_q, vcount_q, hcount_d, vcount_d;
  logic        newline_q, newframe_q, err_q, line_good_q;
  logic        newline_d, newframe_d, err_d, line_good_d;
  logic        red_ctl, grn_ctl, blu_ctl;

  // lock tracking
  lock_state_t     state_q, state_d;
  logic [GL_W-1:0] gl_q, gl_d;
  logic            locked;

  always_comb begin
    red_s1_d = i_TMDS_red;
    grn_s1_d = i_TMDS_grn;
    blu_s1_d = i_TMDS_blu;
    vld_s1_d = 1'b1;
  end

  always_comb begin
    red_ctl     = is_ctl(red_s1_q);
    grn_ctl     = is_ctl(grn_s1_q);
    blu_ctl     = is_ctl(blu_s1_q);
    red_d       = red_q;
    grn_d       = grn_q;
    blu_d       = blu_q;
    de_d        = de_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    line_good_d = line_good_q;
    newline_d   = 1'b0;
    newframe_d  = 1'b0;
    err_d       = 1'b0;
    // an empty stage 1 (just after reset) holds everything and raises no strobes
    if (vld_s1_q) begin
      de_d = ~blu_ctl;
      if (blu_ctl) begin
        {vsync_d, hsync_d} = ctl_code(blu_s1_q);
      end else begin
        red_d = decode(red_s1_q);
        grn_d = decode(grn_s1_q);
        blu_d = decode(blu_s1_q);
      end
      err_d = (red_ctl != blu_ctl) || (grn_ctl != blu_ctl) ||
              (blu_ctl && red_ctl && (ctl_code(red_s1_q) != 2'b00)) ||
              (blu_ctl && grn_ctl && (ctl_code(grn_s1_q) != 2'b00));
      newline_d  = de_q && !de_d;
      newframe_d = (vsync_q != VSYNC_ACTIVE) && (vsync_d == VSYNC_ACTIVE);
      if (newline_d) begin
        hcount_d    = 12'd0;
        line_good_d = (hcount_q == H_LAST);
      end else if (de_d) begin
        if (!de_q)                 hcount_d = 12'd0;
        else if (hcount_q != HC_MAX) hcount_d = hcount_q + 12'd1;
      end
      if (newframe_d) begin
        vcount_d = 12'd0;
      end else if (newline_d) begin
        vcount_d = (vcount_q >= V_LAST) ? V_LAST : vcount_q + 12'd1;
      end
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      red_s1_q    <= '0;
      grn_s1_q    <= '0;
      blu_s1_q    <= '0;
      vld_s1_q    <= 1'b0;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      newline_q   <= 1'b0;
      newframe_q  <= 1'b0;
      err_q       <= 1'b0;
      line_good_q <= 1'b0;
    end else begin
      red_s1_q    <= red_s1_d;
      grn_s1_q    <= grn_s1_d;
      blu_s1_q    <= blu_s1_d;
      vld_s1_q    <= vld_s1_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      newline_q   <= newline_d;
      newframe_q  <= newframe_d;
      err_q       <= err_d;
      line_good_q <= line_good_d;
    end
  end

  // lock FSM: state register
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      state_q <= S_UNLOCKED;
      gl_q    <= '0;
    end else begin
      state_q <= state_d;
      gl_q    <= gl_d;
    end
  end

  // lock FSM: next state, driven by the registered strobes so it trails them by one edge
  always_comb begin
    state_d = state_q;
    gl_d    = gl_q;
    if (err_q || (newline_q && !line_good_q)) begin
      gl_d    = '0;
      state_d = S_UNLOCKED;
    end else if (newline_q && line_good_q && (state_q == S_UNLOCKED)) begin
      gl_d = (gl_q >= GL_MAX) ? gl_q : gl_q + 1'b1;
      if (gl_d == GL_MAX) state_d = S_LOCKED;
    end
  end

  // lock FSM: outputs
  always_comb begin
    locked = (state_q == S_LOCKED);
  end

  assign o_red      = red_q;
  assign o_grn      = grn_q;
  assign o_blu      = blu_q;
  assign o_de       = de_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_hcount   = hcount_q;
  assign o_vcount   = vcount_q;
  assign o_newline  = newline_q;
  assign o_newframe = newframe_q;
  assign o_locked   = locked;
  assign o_err      = err_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Scoreboard bench for tmds_rx_decoder: a behavioural model queues the expected outputs
// of every driven word, and they are compared two edges later.
module tb_tmds_rx_decoder;

  localparam int H_ACT  = 640;
  localparam int V_ACT  = 8;
  localparam int LOCK_N = 4;
  localparam bit VS_ACT = 1'b1;

  localparam logic [9:0] W_ZERO = 10'b0100000000;
  localparam logic [9:0] W_INV  = 10'b1011111111;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [9:0]  i_TMDS_red, i_TMDS_grn, i_TMDS_blu;
  logic [7:0]  o_red, o_grn, o_blu;
  logic        o_de, o_hsync, o_vsync, o_newline, o_newframe, o_locked, o_err;
  logic [11:0] o_hcount, o_vcount;

  always #5 clk = ~clk;

  tmds_rx_decoder #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LOCK_LINES(LOCK_N), .VSYNC_ACTIVE(VS_ACT)
  ) dut (
    .i_pixclk(clk), .i_reset_n(i_reset_n),
    .i_TMDS_red(i_TMDS_red), .i_TMDS_grn(i_TMDS_grn), .i_TMDS_blu(i_TMDS_blu),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_de(o_de),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_hcount(o_hcount), .o_vcount(o_vcount),
    .o_newline(o_newline), .o_newframe(o_newframe), .o_locked(o_locked), .o_err(o_err)
  );

  typedef struct packed {
    logic        de, hs, vs;
    logic [7:0]  r, g, b;
    logic [11:0] hc, vc;
    logic        nl, nf, lk, er;
  } exp_t;

  exp_t sb_q[$];
  exp_t mdl;
  int   m_gl;
  bit   m_lg;
  int   disp [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] tok(input int c);
    case (c)
      0: return 10'b1101010100;
      1: return 10'b0010101011;
      2: return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int tok_idx(input logic [9:0] w);
    for (int c = 0; c < 4; c++) if (w == tok(c)) return c;
    return -1;
  endfunction

  function automatic logic [7:0] dec_word(input logic [9:0] q);
    logic [7:0] m;
    logic [7:0] d;
    m    = q[7:0] ^ {8{q[9]}};
    d[0] = m[0];
    for (int i = 1; i < 8; i++) d[i] = m[i] ^ m[i-1] ^ ~q[8];
    return d;
  endfunction

  // reference TMDS transmit encoder with per-channel running disparity
  task automatic encode(input logic [7:0] d, input int ch, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp[ch] == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp[ch] > 0 && n1q > n0q) || (disp[ch] < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp[ch] += 2 * int'(qm[8]) + (n0q - n1q);
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp[ch] += -2 * int'(!qm[8]) + (n1q - n0q);
    end
  endtask

  task automatic model_step(input logic [9:0] r, g, b, input logic [7:0] er, eg, eb,
                            output exp_t e);
    exp_t p;
    exp_t n;
    int   ri, gi, bi;
    p  = mdl;
    n  = p;
    ri = tok_idx(r);
    gi = tok_idx(g);
    bi = tok_idx(b);
    n.de = (bi < 0);
    if (bi >= 0) {n.vs, n.hs} = 2'(bi);
    else begin
      n.r = er; n.g = eg; n.b = eb;
    end
    n.er = ((ri >= 0) != (bi >= 0)) || ((gi >= 0) != (bi >= 0)) || (bi >= 0 && (ri > 0 || gi > 0));
    n.nl = p.de && !n.de;
    n.nf = (p.vs != VS_ACT) && (n.vs == VS_ACT);
    if (n.nl) n.hc = 12'd0;
    else if (n.de) n.hc = !p.de ? 12'd0 : (p.hc == 12'hfff ? p.hc : p.hc + 12'd1);
    if (n.nf) n.vc = 12'd0;
    else if (n.nl) n.vc = (int'(p.vc) >= V_ACT - 1) ? 12'(V_ACT - 1) : p.vc + 12'd1;
    if (p.er || (p.nl && !m_lg)) begin
      m_gl = 0;
      n.lk = 1'b0;
    end else if (p.nl && m_lg && !p.lk) begin
      if (m_gl < LOCK_N) m_gl++;
      if (m_gl == LOCK_N) n.lk = 1'b1;
    end
    if (n.nl) m_lg = (int'(p.hc) == H_ACT - 1);
    mdl = n;
    e   = n;
  endtask

  task automatic compare(input exp_t e);
    check_val("data",  {o_de, o_red, o_grn, o_blu},              {e.de, e.r, e.g, e.b});
    check_val("sync",  {o_vsync, o_hsync},                       {e.vs, e.hs});
    check_val("count", {o_hcount, o_vcount},                     {e.hc, e.vc});
    check_val("flags", {o_newline, o_newframe, o_locked, o_err}, {e.nl, e.nf, e.lk, e.er});
  endtask

  task automatic drive(input bit rst_n, input logic [9:0] r, g, b, input logic [7:0] er, eg, eb);
    exp_t e;
    i_reset_n  = rst_n;
    i_TMDS_red = r;
    i_TMDS_grn = g;
    i_TMDS_blu = b;
    if (!rst_n) begin
      // reset kills the word already in flight as well as this one
      sb_q.delete();
      mdl  = '0;
      m_gl = 0;
      m_lg = 1'b0;
      sb_q.push_back('0);
      sb_q.push_back('0);
    end else begin
      model_step(r, g, b, er, eg, eb, e);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 1) compare(sb_q.pop_front());
  endtask

  task automatic ctl(input int c, input int n);
    repeat (n) drive(1'b1, tok(0), tok(0), tok(c), 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pix(input logic [7:0] r, g, b);
    logic [9:0] qr, qg, qb;
    encode(r, 2, qr);
    encode(g, 1, qg);
    encode(b, 0, qb);
    drive(1'b1, qr, qg, qb, r, g, b);
  endtask

  task automatic line(input int y, input int npix);
    for (int x = 0; x < npix; x++) pix(8'(x), 8'(y * 16), 8'(x ^ y));
    ctl(0, 4);
    ctl(1, 8);
    ctl(0, 4);
  endtask

  task automatic vblank();
    ctl(2, 20);
    ctl(0, 4);
  endtask

  initial begin
    mdl = '0;
    m_gl = 0;
    m_lg = 1'b0;
    for (int c = 0; c < 3; c++) disp[c] = 0;
    i_reset_n  = 1'b0;
    i_TMDS_red = '0;
    i_TMDS_grn = '0;
    i_TMDS_blu = '0;

    repeat (3) drive(1'b0, '0, '0, '0, 8'h00, 8'h00, 8'h00);
    ctl(0, 10);

    repeat (2) drive(1'b1, W_ZERO, W_ZERO, W_ZERO, dec_word(W_ZERO), dec_word(W_ZERO), dec_word(W_ZERO));
    repeat (2) drive(1'b1, W_INV, W_INV, W_INV, dec_word(W_INV), dec_word(W_INV), dec_word(W_INV));
    ctl(0, 4);

    for (int v = 0; v < 256; v++) pix(8'(v), 8'(v) ^ 8'h5a, ~8'(v));
    ctl(0, 8);

    // frame 1: lock after the fourth line, vcount saturates at V_ACT-1
    vblank();
    for (int y = 0; y < 10; y++) line(y, H_ACT);

    // frame 2: one short line drops lock, four good lines restore it
    vblank();
    line(0, H_ACT);
    line(1, H_ACT);
    line(2, H_ACT - 1);
    for (int y = 3; y < 8; y++) line(y, H_ACT);

    // green carries data during a control period
    ctl(0, 4);
    drive(1'b1, tok(0), W_ZERO, tok(0), 8'h00, 8'h00, 8'h00);
    ctl(0, 6);

    // reset mid-line, then the rest of the line restarts counting
    for (int x = 0; x < 302; x++) pix(8'(x), 8'h33, 8'h44);
    drive(1'b0, tok(0), tok(0), tok(0), 8'h00, 8'h00, 8'h00);
    for (int x = 302; x < H_ACT; x++) pix(8'(x), 8'h33, 8'h44);
    ctl(0, 16);
    ctl(0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
